qspi_sclk_engine: RTL and testbench

// - Programmable QSPI serial-clock engine. Next generation of the free-running SCLK divider.
// - Generates a burst of exactly N SCLK cycles per request, in any of the four CPOL/CPHA modes.
// - Emits per-edge launch/sample strobes in the hclk domain for the shift-register datapath.
// - Sits between the AHB register block (divider, mode, count) and the QSPI shift/CS logic.
//

---
 rtl/qspi_sclk_engine_if.sv | 61 ++++++
 rtl/qspi_sclk_engine.sv | 190 +++++++++++++++++++
 tb/tb_qspi_sclk_engine.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/qspi_sclk_engine_if.sv
// qspi_sclk_engine_if: config/handshake bundle for the SCLK engine.
// Delay inputs exist only with QSPI_SCLK_DELAY_EN defined.
interface qspi_sclk_engine_if #(
  parameter int DIV_W = 8,
  parameter int CNT_W = 16
);
  logic [DIV_W-1:0] clk_div_in;
  logic             cpol_in;
  logic             cpha_in;
  logic [CNT_W-1:0] num_cycles_in;
  logic             start_in;
  logic             abort_in;
`ifdef QSPI_SCLK_DELAY_EN
  logic [DIV_W-1:0] lead_dly_in;
  logic [DIV_W-1:0] trail_dly_in;
`endif
  logic             busy_out;
  logic             done_out;
  logic             sclk_out;
  logic             launch_stb_out;
  logic             sample_stb_out;
  logic [CNT_W-1:0] cycle_cnt_out;

  modport master (
    output clk_div_in,
    output cpol_in,
    output cpha_in,
    output num_cycles_in,
    output start_in,
    output abort_in,
`ifdef QSPI_SCLK_DELAY_EN
    output lead_dly_in,
    output trail_dly_in,
`endif
    input  busy_out,
    input  done_out,
    input  sclk_out,
    input  launch_stb_out,
    input  sample_stb_out,
    input  cycle_cnt_out
  );

  modport slave (
    input  clk_div_in,
    input  cpol_in,
    input  cpha_in,
    input  num_cycles_in,
    input  start_in,
    input  abort_in,
`ifdef QSPI_SCLK_DELAY_EN
    input  lead_dly_in,
    input  trail_dly_in,
`endif
    output busy_out,
    output done_out,
    output sclk_out,
    output launch_stb_out,
    output sample_stb_out,
    output cycle_cnt_out
  );
endinterface

// File: rtl/qspi_sclk_engine.sv
// qspi_sclk_engine: N-cycle SCLK burst generator with launch/sample strobes.
// Optional lead/trail idle delays are enabled by QSPI_SCLK_DELAY_EN.
module qspi_sclk_engine #(
  parameter int DIV_W = 8,
  parameter int CNT_W = 16
) (
  input logic               hclk,
  input logic               hreset_n,
  qspi_sclk_engine_if.slave bus
);

`ifdef QSPI_SCLK_DELAY_EN
  typedef enum logic [1:0] {
    S_IDLE, S_LEAD, S_RUN, S_TRAIL
  } state_e;
`else
  typedef enum logic [1:0] {
    S_IDLE, S_RUN, S_TRAIL
  } state_e;
`endif

  localparam logic [DIV_W:0] D_ONE =
    {{DIV_W{1'b0}}, 1'b1};
  localparam logic [CNT_W:0] E_ONE =
    {{CNT_W{1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] C_ONE =
    {{(CNT_W-1){1'b0}}, 1'b1};

  state_e           state_q;
  logic [DIV_W-1:0] div_q;
  logic             cpol_q;
  logic             cpha_q;
  logic [CNT_W:0]   edges_q;
  logic [DIV_W:0]   div_cnt_q;
  logic [CNT_W:0]   edge_q;
  logic             busy_q;
  logic             done_q;
  logic             sclk_q;
  logic             launch_q;
  logic             sample_q;
  logic [CNT_W-1:0] ccnt_q;
`ifdef QSPI_SCLK_DELAY_EN
  logic [DIV_W-1:0] lead_q;
  logic [DIV_W-1:0] trail_q;
  logic             lead_end_d;
`endif

  logic           wrap_d;
  logic [CNT_W:0] edge_d;
  logic           last_d;
  logic           odd_d;
  logic           launch_d;
  logic           sample_d;
  logic           tr_end_d;
  logic           cnt_inc_d;
  state_e         start_st_d;

  // Edge bookkeeping and strobe decode for the next divider wrap.
  always_comb begin
    wrap_d    = (div_cnt_q == {1'b0, div_q});
    edge_d    = edge_q + E_ONE;
    last_d    = (edge_d == edges_q);
    odd_d     = edge_d[0];
    launch_d  = 1'b0;
    sample_d  = 1'b0;
    unique case (1'b1)
      cpha_q: begin
        launch_d = odd_d;
        sample_d = !odd_d;
      end
      !cpha_q: begin
        launch_d = !odd_d && !last_d;
        sample_d = odd_d;
      end
    endcase
    cnt_inc_d = !odd_d &&
      (ccnt_q != edges_q[CNT_W:1]);
`ifdef QSPI_SCLK_DELAY_EN
    tr_end_d = (div_cnt_q ==
      ({1'b0, div_q} + {1'b0, trail_q}));
    lead_end_d = (div_cnt_q ==
      ({1'b0, lead_q} - D_ONE));
`else
    tr_end_d = wrap_d;
`endif
    start_st_d = (bus.num_cycles_in == '0) ?
      S_TRAIL : S_RUN;
`ifdef QSPI_SCLK_DELAY_EN
    if (bus.lead_dly_in != '0)
      start_st_d = S_LEAD;
`endif
  end

  // Burst FSM; every output is a register.
  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) begin
      state_q   <= S_IDLE;
      div_q     <= '0;
      cpol_q    <= 1'b0;
      cpha_q    <= 1'b0;
      edges_q   <= '0;
      div_cnt_q <= '0;
      edge_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      sclk_q    <= 1'b0;
      launch_q  <= 1'b0;
      sample_q  <= 1'b0;
      ccnt_q    <= '0;
`ifdef QSPI_SCLK_DELAY_EN
      lead_q    <= '0;
      trail_q   <= '0;
`endif
    end else begin
      launch_q <= 1'b0;
      sample_q <= 1'b0;
      done_q   <= 1'b0;
      if (bus.abort_in) begin
        state_q <= S_IDLE;
        busy_q  <= 1'b0;
        sclk_q  <= cpol_q;
      end else begin
        unique case (state_q)
          S_IDLE: begin
            if (bus.start_in) begin
              div_q     <= bus.clk_div_in;
              cpol_q    <= bus.cpol_in;
              cpha_q    <= bus.cpha_in;
              edges_q   <= {bus.num_cycles_in, 1'b0};
`ifdef QSPI_SCLK_DELAY_EN
              lead_q    <= bus.lead_dly_in;
              trail_q   <= bus.trail_dly_in;
`endif
              div_cnt_q <= '0;
              edge_q    <= '0;
              ccnt_q    <= '0;
              busy_q    <= 1'b1;
              sclk_q    <= bus.cpol_in;
              state_q   <= start_st_d;
            end
          end
`ifdef QSPI_SCLK_DELAY_EN
          S_LEAD: begin
            if (lead_end_d) begin
              div_cnt_q <= '0;
              state_q   <= (edges_q == '0) ?
                S_TRAIL : S_RUN;
            end else begin
              div_cnt_q <= div_cnt_q + D_ONE;
            end
          end
`endif
          S_RUN: begin
            if (wrap_d) begin
              div_cnt_q <= '0;
              edge_q    <= edge_d;
              sclk_q    <= !sclk_q;
              launch_q  <= launch_d;
              sample_q  <= sample_d;
              if (cnt_inc_d)
                ccnt_q <= ccnt_q + C_ONE;
              if (last_d)
                state_q <= S_TRAIL;
            end else begin
              div_cnt_q <= div_cnt_q + D_ONE;
            end
          end
          S_TRAIL: begin
            if (tr_end_d) begin
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= S_IDLE;
            end else begin
              div_cnt_q <= div_cnt_q + D_ONE;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.busy_out       = busy_q;
  assign bus.done_out       = done_q;
  assign bus.sclk_out       = sclk_q;
  assign bus.launch_stb_out = launch_q;
  assign bus.sample_stb_out = sample_q;
  assign bus.cycle_cnt_out  = ccnt_q;

endmodule

// File: tb/tb_qspi_sclk_engine.sv
// tb_qspi_sclk_engine: directed + random bursts vs. timing-formula model.
// Define QSPI_SCLK_DELAY_EN to also cover lead/trail delays.
module tb_qspi_sclk_engine;
  logic hclk = 1'b0;
  logic hreset_n = 1'b0;
  int checks = 0;
  int failures = 0;
  int cur_t = 0;

  qspi_sclk_engine_if #(.DIV_W(8), .CNT_W(16)) bus ();

  qspi_sclk_engine #(.DIV_W(8), .CNT_W(16)) dut (
    .hclk     (hclk),
    .hreset_n (hreset_n),
    .bus      (bus.slave)
  );

  always #5 hclk = ~hclk;

  task automatic tick();
    @(posedge hclk);
    #2;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s t=%0d observed=%0h expected=%0h",
             tag, cur_t, obs, exp);
    end
  endtask

  // Expected outputs t cycles after the accept cycle, from the
  // edge-time formula T+1+lead+k*(div+1) and done time.
  task automatic model(input int t, d, cp, ch, n, l, r,
                       output int eb, ed, es, el, esa, ec);
    int p, tdone, ph, edges, k;
    bit en;
    p = d + 1;
    tdone = 1 + l + (2*n + 1)*p + r;
    ph = t - 1 - l;
    edges = 0;
    en = 0;
    k = 0;
    if (ph >= 0) begin
      edges = ph / p;
      if (edges > 2*n) edges = 2*n;
      if ((ph % p) == 0 && ph/p >= 1 && ph/p <= 2*n) begin
        en = 1;
        k = ph / p;
      end
    end
    es  = cp ^ (edges % 2);
    el  = (en && (ch != 0 ? (k%2 == 1)
                          : (k%2 == 0 && k != 2*n))) ? 1 : 0;
    esa = (en && (ch != 0 ? (k%2 == 0) : (k%2 == 1))) ? 1 : 0;
    ec  = edges / 2;
    eb  = (t < tdone) ? 1 : 0;
    ed  = (t == tdone) ? 1 : 0;
  endtask

  task automatic burst(input int d, cp, ch, n, l, r,
                       input int ab, mess, keep);
    int tdone, last, ta;
    int eb, ed, es, el, esa, ec;
    tdone = 1 + l + (2*n + 1)*(d + 1) + r;
    last = (ab > 0) ? ab + 3 : (keep != 0 ? tdone : tdone + 1);
    bus.clk_div_in    = 8'(d);
    bus.cpol_in       = 1'(cp);
    bus.cpha_in       = 1'(ch);
    bus.num_cycles_in = 16'(n);
`ifdef QSPI_SCLK_DELAY_EN
    bus.lead_dly_in   = 8'(l);
    bus.trail_dly_in  = 8'(r);
`endif
    bus.abort_in      = 1'b0;
    bus.start_in      = 1'b1;
    for (int t = 1; t <= last; t++) begin
      tick();
      cur_t = t;
      ta = (ab > 0 && t > ab) ? ab : t;
      model(ta, d, cp, ch, n, l, r, eb, ed, es, el, esa, ec);
      if (ab > 0 && t > ab) begin
        eb = 0; ed = 0; es = cp; el = 0; esa = 0;
      end
      chk("busy",   32'(bus.busy_out),       32'(eb));
      chk("done",   32'(bus.done_out),       32'(ed));
      chk("sclk",   32'(bus.sclk_out),       32'(es));
      chk("launch", 32'(bus.launch_stb_out), 32'(el));
      chk("sample", 32'(bus.sample_stb_out), 32'(esa));
      chk("cnt",    32'(bus.cycle_cnt_out),  32'(ec));
      if (ab > 0 && t == ab) bus.abort_in = 1'b1;
      if (keep != 0)
        bus.start_in = 1'b1;
      else if (mess != 0 && t < tdone - 1 && (ab == 0 || t < ab))
        bus.start_in = 1'($urandom_range(1, 0));
      else
        bus.start_in = 1'b0;
      if (mess != 0) begin
        bus.clk_div_in    = 8'($urandom_range(7, 0));
        bus.cpol_in       = 1'($urandom_range(1, 0));
        bus.cpha_in       = 1'($urandom_range(1, 0));
        bus.num_cycles_in = 16'($urandom_range(9, 0));
`ifdef QSPI_SCLK_DELAY_EN
        bus.lead_dly_in   = 8'($urandom_range(5, 0));
        bus.trail_dly_in  = 8'($urandom_range(5, 0));
`endif
      end
    end
    bus.abort_in = 1'b0;
  endtask

  initial begin
    int d, cp, ch, n, l, r, ab, ms, kp, td;
    bus.clk_div_in    = '0;
    bus.cpol_in       = 1'b0;
    bus.cpha_in       = 1'b0;
    bus.num_cycles_in = '0;
    bus.start_in      = 1'b0;
    bus.abort_in      = 1'b0;
`ifdef QSPI_SCLK_DELAY_EN
    bus.lead_dly_in   = '0;
    bus.trail_dly_in  = '0;
`endif
    tick();
    tick();
    chk("rst_busy", 32'(bus.busy_out),       32'd0);
    chk("rst_done", 32'(bus.done_out),       32'd0);
    chk("rst_sclk", 32'(bus.sclk_out),       32'd0);
    chk("rst_lau",  32'(bus.launch_stb_out), 32'd0);
    chk("rst_smp",  32'(bus.sample_stb_out), 32'd0);
    chk("rst_cnt",  32'(bus.cycle_cnt_out),  32'd0);
    hreset_n = 1'b1;
    tick();

    burst(0, 0, 0, 2, 0, 0, 0, 0, 0);
    burst(3, 1, 1, 1, 0, 0, 0, 0, 0);
    burst(2, 0, 0, 0, 0, 0, 0, 0, 0);
    burst(1, 0, 0, 8, 0, 0, 10, 0, 0);
    burst(2, 0, 1, 3, 0, 0, 0, 1, 0);

    bus.abort_in = 1'b1;
    bus.start_in = 1'b1;
    bus.num_cycles_in = 16'd2;
    tick();
    cur_t = -1;
    chk("idle_abort_busy", 32'(bus.busy_out), 32'd0);
    tick();
    chk("idle_abort_busy2", 32'(bus.busy_out), 32'd0);
    chk("idle_abort_lau", 32'(bus.launch_stb_out), 32'd0);
    bus.abort_in = 1'b0;
    bus.start_in = 1'b0;
    tick();
    chk("idle_abort_busy3", 32'(bus.busy_out), 32'd0);

    burst(1, 1, 0, 2, 0, 0, 0, 0, 1);
    burst(0, 0, 1, 3, 0, 0, 0, 0, 0);

    bus.clk_div_in    = 8'd1;
    bus.cpol_in       = 1'b1;
    bus.cpha_in       = 1'b0;
    bus.num_cycles_in = 16'd8;
    bus.start_in      = 1'b1;
    tick();
    bus.start_in = 1'b0;
    repeat (6) tick();
    cur_t = -2;
    chk("pre_rst_busy", 32'(bus.busy_out), 32'd1);
    #1;
    hreset_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(bus.busy_out),       32'd0);
    chk("mid_rst_sclk", 32'(bus.sclk_out),       32'd0);
    chk("mid_rst_lau",  32'(bus.launch_stb_out), 32'd0);
    chk("mid_rst_smp",  32'(bus.sample_stb_out), 32'd0);
    chk("mid_rst_done", 32'(bus.done_out),       32'd0);
    chk("mid_rst_cnt",  32'(bus.cycle_cnt_out),  32'd0);
    tick();
    hreset_n = 1'b1;
    tick();
    burst(1, 1, 0, 3, 0, 0, 0, 0, 0);

`ifdef QSPI_SCLK_DELAY_EN
    burst(0, 0, 0, 1, 4, 3, 0, 0, 0);
    burst(1, 1, 1, 0, 2, 5, 0, 0, 0);
`endif

    for (int i = 0; i < 25; i++) begin
      d  = $urandom_range(3, 0);
      n  = $urandom_range(4, 0);
      cp = $urandom_range(1, 0);
      ch = $urandom_range(1, 0);
      l  = 0;
      r  = 0;
`ifdef QSPI_SCLK_DELAY_EN
      l  = $urandom_range(3, 0);
      r  = $urandom_range(3, 0);
`endif
      td = 1 + l + (2*n + 1)*(d + 1) + r;
      ab = ($urandom_range(3, 0) == 0) ? $urandom_range(td - 1, 1) : 0;
      ms = $urandom_range(1, 0);
      kp = (ab == 0 && ms == 0 && i < 24 &&
            $urandom_range(3, 0) == 0) ? 1 : 0;
      burst(d, cp, ch, n, l, r, ab, ms, kp);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
